// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding,
// register-index width and the load-use compare.
package hazard_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    HC_RUN   = 1'b0,
    HC_STALL = 1'b1
  } hc_state_t;

  // $zero is hard-wired, so a load targeting it never creates a dependency.
  function automatic logic load_use(
    input logic             memread,
    input logic [REG_W-1:0] ex_rt,
    input logic [REG_W-1:0] id_rs,
    input logic [REG_W-1:0] id_rt,
    input logic             uses_rt
  );
    return memread && (ex_rt != REG_ZERO) &&
           ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating 32-bit event counter with synchronous clear; only built when
// HAZARD_PERF_EN is defined.
`ifdef HAZARD_PERF_EN
module hazard_perf_cnt (
  input  logic        clk,
  input  logic        clr,
  input  logic        inc,
  output logic [31:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= 32'd0;
    end else if (inc && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/hazard_ctrl.sv
// Load-use stall and taken-branch squash control beside the ID stage.
// HAZARD_PERF_EN adds stall_cycles / flush_count performance counters.
//
// state    | meaning
// HC_RUN   | normal issue; evaluates branch and load-use each cycle
// HC_STALL | extra load-use bubbles pending; cnt holds bubbles left
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] IF_ID_rs,
  input  logic [REG_W-1:0] IF_ID_rt,
  input  logic             IF_ID_uses_rt,
  input  logic [REG_W-1:0] ID_EX_rt,
  input  logic             ID_EX_memread,
  input  logic             branch_taken,
  output logic             ctrl,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
`ifdef HAZARD_PERF_EN
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_count,
`endif
  output logic             stall_active
);

  hc_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lu;

  assign lu = load_use(ID_EX_memread, ID_EX_rt, IF_ID_rs, IF_ID_rt, IF_ID_uses_rt);

  // Mealy outputs: they must act on the very edge that follows detection.
  always_comb begin
    ctrl         = 1'b1;
    pc_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    stall_active = 1'b0;
    state_nxt    = state;
    cnt_nxt      = cnt;
    if (rst) begin
      ctrl        = 1'b0;
      pc_write    = 1'b0;
      IF_ID_write = 1'b0;
      IF_ID_flush = 1'b1;
      state_nxt   = HC_RUN;
      cnt_nxt     = '0;
    end else if (branch_taken) begin
      ctrl        = 1'b0;
      IF_ID_flush = 1'b1;
      state_nxt   = HC_RUN;
      cnt_nxt     = '0;
    end else if (state == HC_STALL) begin
      ctrl         = 1'b0;
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      stall_active = 1'b1;
      cnt_nxt      = cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) state_nxt = HC_RUN;
    end else if (lu) begin
      ctrl         = 1'b0;
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      stall_active = 1'b1;
      if (LU_BUBBLES > 1) begin
        state_nxt = HC_STALL;
        cnt_nxt   = CNT_W'(LU_BUBBLES - 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HC_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (stall_active),
    .count (stall_cycles)
  );

  hazard_perf_cnt u_flush_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (IF_ID_flush & ~rst),
    .count (flush_count)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (1, 2, 3 bubbles) share stimulus and
// are checked every cycle against a bubbles-remaining reference model.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, uses_rt, memread, br;
  logic [4:0] if_rs, if_rt, ex_rt;
  logic       ctrl [3];
  logic       pcw  [3];
  logic       ifw  [3];
  logic       fl   [3];
  logic       st   [3];
`ifdef HAZARD_PERF_EN
  logic [31:0] sc [3];
  logic [31:0] fc [3];
`endif

  int checks   = 0;
  int failures = 0;
  int nb  [3] = '{1, 2, 3};
  int rem [3] = '{0, 0, 0};
  logic [31:0] m_sc [3] = '{0, 0, 0};
  logic [31:0] m_fc [3] = '{0, 0, 0};

  hazard_ctrl #(.LU_BUBBLES(1), .CNT_W(2)) u_lu1 (
    .clk(clk), .rst(rst), .IF_ID_rs(if_rs), .IF_ID_rt(if_rt), .IF_ID_uses_rt(uses_rt),
    .ID_EX_rt(ex_rt), .ID_EX_memread(memread), .branch_taken(br),
    .ctrl(ctrl[0]), .pc_write(pcw[0]), .IF_ID_write(ifw[0]), .IF_ID_flush(fl[0]),
`ifdef HAZARD_PERF_EN
    .stall_cycles(sc[0]), .flush_count(fc[0]),
`endif
    .stall_active(st[0]));

  hazard_ctrl #(.LU_BUBBLES(2), .CNT_W(2)) u_lu2 (
    .clk(clk), .rst(rst), .IF_ID_rs(if_rs), .IF_ID_rt(if_rt), .IF_ID_uses_rt(uses_rt),
    .ID_EX_rt(ex_rt), .ID_EX_memread(memread), .branch_taken(br),
    .ctrl(ctrl[1]), .pc_write(pcw[1]), .IF_ID_write(ifw[1]), .IF_ID_flush(fl[1]),
`ifdef HAZARD_PERF_EN
    .stall_cycles(sc[1]), .flush_count(fc[1]),
`endif
    .stall_active(st[1]));

  hazard_ctrl #(.LU_BUBBLES(3), .CNT_W(2)) u_lu3 (
    .clk(clk), .rst(rst), .IF_ID_rs(if_rs), .IF_ID_rt(if_rt), .IF_ID_uses_rt(uses_rt),
    .ID_EX_rt(ex_rt), .ID_EX_memread(memread), .branch_taken(br),
    .ctrl(ctrl[2]), .pc_write(pcw[2]), .IF_ID_write(ifw[2]), .IF_ID_flush(fl[2]),
`ifdef HAZARD_PERF_EN
    .stall_cycles(sc[2]), .flush_count(fc[2]),
`endif
    .stall_active(st[2]));

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a load-use costs N bubbles; a taken branch or reset cancels what is left.
  task automatic model_compare();
    logic lu_hit, e_ctrl, e_pcw, e_ifw, e_fl, e_st;
    lu_hit = memread && (ex_rt != 5'd0) && ((ex_rt == if_rs) || (uses_rt && (ex_rt == if_rt)));
    for (int i = 0; i < 3; i++) begin
      e_ctrl = 1'b1; e_pcw = 1'b1; e_ifw = 1'b1; e_fl = 1'b0; e_st = 1'b0;
      if (rst) begin
        e_ctrl = 1'b0; e_pcw = 1'b0; e_ifw = 1'b0; e_fl = 1'b1;
      end else if (br) begin
        e_ctrl = 1'b0; e_fl = 1'b1;
      end else if (rem[i] > 0 || lu_hit) begin
        e_ctrl = 1'b0; e_pcw = 1'b0; e_ifw = 1'b0; e_st = 1'b1;
      end
      chk1($sformatf("n%0d_ctrl", nb[i]), ctrl[i], e_ctrl);
      chk1($sformatf("n%0d_pc_write", nb[i]), pcw[i], e_pcw);
      chk1($sformatf("n%0d_if_id_write", nb[i]), ifw[i], e_ifw);
      chk1($sformatf("n%0d_if_id_flush", nb[i]), fl[i], e_fl);
      chk1($sformatf("n%0d_stall_active", nb[i]), st[i], e_st);
`ifdef HAZARD_PERF_EN
      chk32($sformatf("n%0d_stall_cycles", nb[i]), sc[i], m_sc[i]);
      chk32($sformatf("n%0d_flush_count", nb[i]), fc[i], m_fc[i]);
`endif
      if (rst || br)      rem[i] = 0;
      else if (rem[i] > 0) rem[i] = rem[i] - 1;
      else if (lu_hit)    rem[i] = nb[i] - 1;
      if (rst) begin
        m_sc[i] = 0; m_fc[i] = 0;
      end else begin
        if (e_st && m_sc[i] != 32'hFFFF_FFFF) m_sc[i] = m_sc[i] + 1;
        if (e_fl && m_fc[i] != 32'hFFFF_FFFF) m_fc[i] = m_fc[i] + 1;
      end
    end
  endtask

  task automatic step(input logic r, input logic b, input logic mr, input logic [4:0] ert,
                      input logic [4:0] rs, input logic [4:0] rt, input logic ur);
    @(posedge clk);
    #1;
    rst = r; br = b; memread = mr; ex_rt = ert; if_rs = rs; if_rt = rt; uses_rt = ur;
    @(negedge clk);
    model_compare();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0);
  endtask

  initial begin
    rst = 1'b1; br = 1'b0; memread = 1'b0; ex_rt = 5'd0; if_rs = 5'd0; if_rt = 5'd0; uses_rt = 1'b0;

    // Reset held two cycles, then a plain cycle.
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0);
      chk1("rst_ctrl", ctrl[0], 1'b0);
      chk1("rst_pc_write", pcw[0], 1'b0);
      chk1("rst_flush", fl[0], 1'b1);
    end
    idle();
    chk1("run_ctrl", ctrl[0], 1'b1);
    chk1("run_pc_write", pcw[0], 1'b1);

    // rs match: one bubble at N=1, two at N=2, three at N=3.
    step(1'b0, 1'b0, 1'b1, 5'd8, 5'd8, 5'd2, 1'b0);
    chk1("lu1_ctrl_b1", ctrl[0], 1'b0);
    chk1("lu1_ifw_b1", ifw[0], 1'b0);
    chk1("lu2_stall_b1", st[1], 1'b1);
    idle();
    chk1("lu1_ctrl_after", ctrl[0], 1'b1);
    chk1("lu2_stall_b2", st[1], 1'b1);
    chk1("lu3_ctrl_b2", ctrl[2], 1'b0);
    idle();
    chk1("lu2_ctrl_after", ctrl[1], 1'b1);
    chk1("lu3_ctrl_b3", ctrl[2], 1'b0);
    idle();
    chk1("lu3_ctrl_after", ctrl[2], 1'b1);

    // rt match only counts when the instruction reads rt; $zero never hazards.
    step(1'b0, 1'b0, 1'b1, 5'd9, 5'd3, 5'd9, 1'b0);
    chk1("no_uses_rt_ctrl", ctrl[1], 1'b1);
    step(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    chk1("zero_reg_ctrl", ctrl[1], 1'b1);
    step(1'b0, 1'b0, 1'b1, 5'd9, 5'd3, 5'd9, 1'b1);
    chk1("rt_hazard_stall", st[1], 1'b1);
    idle();
    chk1("rt_hazard_stall2", st[1], 1'b1);
    idle();

    // Branch in the second stall cycle of N=3 cancels the third bubble.
    step(1'b0, 1'b0, 1'b1, 5'd8, 5'd8, 5'd2, 1'b0);
    step(1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0);
    chk1("br_cancel_flush", fl[2], 1'b1);
    chk1("br_cancel_pcw", pcw[2], 1'b1);
    idle();
    chk1("br_cancel_ctrl", ctrl[2], 1'b1);

    // Branch and load-use together: branch wins, no stall.
    step(1'b0, 1'b1, 1'b1, 5'd8, 5'd8, 5'd2, 1'b0);
    chk1("br_prio_stall", st[1], 1'b0);
    chk1("br_prio_flush", fl[1], 1'b1);

    // Counter scenario: after reset, 3 load-uses then 4 taken branches.
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b1, 5'd8, 5'd8, 5'd2, 1'b0);
      idle();
    end
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0);
    idle();
`ifdef HAZARD_PERF_EN
    chk32("perf_stall_cycles", sc[1], 32'd6);
    chk32("perf_flush_count", fc[1], 32'd4);
`endif

    for (int k = 0; k < 3000; k++) begin
      step(1'($urandom_range(63) == 0), 1'($urandom_range(7) == 0), 1'($urandom_range(1)),
           5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
           1'($urandom_range(1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
